// File: rtl/iob_eth_rx_ring_if.sv
// Receive-ring bundle: byte stream in, head-slot read port, queue status out.
//   master: frame source / CPU-DMA side (drives stream, read and pop controls)
//   slave : the ring itself (drives read data, status and drop counter)
interface iob_eth_rx_ring_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SLOT_ADDR_W = 11,
  parameter int unsigned NSLOTS_W    = 2
);
  localparam int unsigned RD_ADDR_W = SLOT_ADDR_W - $clog2(DATA_W / 8);

  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_sof;
  logic                   in_eof;
  logic                   in_err;
  logic                   rd_en;
  logic [RD_ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]      rd_data;
  logic                   pop;
  logic                   empty;
  logic                   full;
  logic [NSLOTS_W:0]      count;
  logic [SLOT_ADDR_W:0]   head_len;
  logic                   head_crc_ok;
  logic [15:0]            drop_cnt;
  logic                   clr_drop;

  modport master (
    output in_valid, in_data, in_sof, in_eof, in_err, rd_en, rd_addr, pop, clr_drop,
    input  rd_data, empty, full, count, head_len, head_crc_ok, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_eof, in_err, rd_en, rd_addr, pop, clr_drop,
    output rd_data, empty, full, count, head_len, head_crc_ok, drop_cnt
  );
endinterface

// File: rtl/iob_eth_rx_ring.sv
// Multi-slot Ethernet RX frame ring: queues up to 2^NSLOTS_W frames and
// exposes the oldest one as word-addressable memory with length/CRC status.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ring_if    : slave side of iob_eth_rx_ring_if (stream in, read/pop, status)
module iob_eth_rx_ring #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SLOT_ADDR_W = 11,
  parameter int unsigned NSLOTS_W    = 2,
  parameter int unsigned DROP_BAD    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  iob_eth_rx_ring_if.slave   ring_if
);
  localparam int unsigned BPW    = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BPW);
  localparam int unsigned WORD_W = SLOT_ADDR_W - LANE_W;
  localparam int unsigned OFF_W  = SLOT_ADDR_W + 1;
  localparam int unsigned PTR_W  = NSLOTS_W + 1;
  localparam int unsigned NSLOTS = 2 ** NSLOTS_W;
  localparam int unsigned MEM_AW = NSLOTS_W + WORD_W;
  localparam int unsigned DEPTH  = 2 ** MEM_AW;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_e;

  state_e                  state_q, state_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OFF_W-1:0]        len_tbl_q [NSLOTS];
  logic                    crc_tbl_q [NSLOTS];
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]        count_q, count_d;
  logic                    empty_q, full_q;
  logic [OFF_W-1:0]        head_len_q, head_len_d;
  logic                    head_crc_q, head_crc_d;
  logic [DATA_W-1:0]       rd_data_q;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic                    we_c;
  logic [SLOT_ADDR_W-1:0]  wr_off_c;
  logic                    commit_c;
  logic [OFF_W-1:0]        commit_len_c;
  logic                    commit_ok_c;
  logic                    drop_c;
  logic                    drop_bad_c;
  logic                    pop_c;
  logic [NSLOTS_W-1:0]     wr_slot_c, rd_slot_c, head_slot_c;

  // Write FSM, pointer/counter next-state and registered status next-state
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    we_c         = 1'b0;
    wr_off_c     = off_q[SLOT_ADDR_W-1:0];
    commit_c     = 1'b0;
    commit_len_c = off_q + OFF_W'(1);
    commit_ok_c  = ~ring_if.in_err;
    drop_c       = 1'b0;
    drop_bad_c   = (DROP_BAD != 0) && ring_if.in_err;
    wr_slot_c    = wr_ptr_q[NSLOTS_W-1:0];
    rd_slot_c    = rd_ptr_q[NSLOTS_W-1:0];

    if (ring_if.in_valid) begin
      unique case (state_q)
        S_IDLE, S_RECV: begin
          if (ring_if.in_sof) begin
            // A sof inside RECV abandons the partial frame and restarts in the same slot
            if (state_q == S_RECV) drop_c = 1'b1;
            if (state_q == S_IDLE && full_q) begin
              drop_c  = 1'b1;
              state_d = ring_if.in_eof ? S_IDLE : S_DROP;
            end else begin
              we_c         = 1'b1;
              wr_off_c     = '0;
              off_d        = OFF_W'(1);
              commit_len_c = OFF_W'(1);
              state_d      = S_RECV;
              if (ring_if.in_eof) begin
                off_d   = '0;
                state_d = S_IDLE;
                if (drop_bad_c) drop_c = 1'b1;
                else            commit_c = 1'b1;
              end
            end
          end else if (state_q == S_RECV) begin
            if (off_q[SLOT_ADDR_W]) begin
              // Slot already holds 2^SLOT_ADDR_W bytes: this byte overflows it
              drop_c  = 1'b1;
              off_d   = '0;
              state_d = ring_if.in_eof ? S_IDLE : S_DROP;
            end else begin
              we_c  = 1'b1;
              off_d = off_q + OFF_W'(1);
              if (ring_if.in_eof) begin
                off_d   = '0;
                state_d = S_IDLE;
                if (drop_bad_c) drop_c = 1'b1;
                else            commit_c = 1'b1;
              end
            end
          end
        end
        S_DROP: begin
          if (ring_if.in_eof) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    pop_c    = ring_if.pop & ~empty_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(commit_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    count_d  = wr_ptr_d - rd_ptr_d;

    if (ring_if.clr_drop)                      drop_cnt_d = '0;
    else if (drop_c && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    else                                       drop_cnt_d = drop_cnt_q;

    // Head status follows the next head slot, bypassing a same-cycle commit into it
    head_slot_c = rd_ptr_d[NSLOTS_W-1:0];
    if (commit_c && wr_slot_c == head_slot_c) begin
      head_len_d = commit_len_c;
      head_crc_d = commit_ok_c;
    end else begin
      head_len_d = len_tbl_q[head_slot_c];
      head_crc_d = crc_tbl_q[head_slot_c];
    end
  end

  // State, pointers, slot table and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      off_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      head_len_q <= '0;
      head_crc_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < int'(NSLOTS); i++) begin
        len_tbl_q[i] <= '0;
        crc_tbl_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == PTR_W'(NSLOTS));
      head_len_q <= head_len_d;
      head_crc_q <= head_crc_d;
      if (commit_c) begin
        len_tbl_q[wr_slot_c] <= commit_len_c;
        crc_tbl_q[wr_slot_c] <= commit_ok_c;
      end
      if (ring_if.rd_en) rd_data_q <= mem_q[{rd_slot_c, ring_if.rd_addr}];
    end
  end

  // Frame storage: one byte lane written per accepted byte (little-endian)
  always_ff @(posedge clk) begin
    if (we_c)
      mem_q[{wr_slot_c, wr_off_c[SLOT_ADDR_W-1:LANE_W]}][{wr_off_c[LANE_W-1:0], 3'b000} +: 8]
        <= ring_if.in_data;
  end

  assign ring_if.rd_data     = rd_data_q;
  assign ring_if.empty       = empty_q;
  assign ring_if.full        = full_q;
  assign ring_if.count       = count_q;
  assign ring_if.head_len    = head_len_q;
  assign ring_if.head_crc_ok = head_crc_q;
  assign ring_if.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_iob_eth_rx_ring.sv
// Scoreboard bench for iob_eth_rx_ring: frames expected to commit are queued
// as they are sent and compared when the head slot is read and popped.
// Two instances share the stimulus: dut0 keeps bad frames, dut1 drops them.
module tb_iob_eth_rx_ring;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SLOT_ADDR_W = 11;
  localparam int unsigned NSLOTS_W    = 2;
  localparam int unsigned RA_W        = SLOT_ADDR_W - 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid, in_sof, in_eof, in_err, rd_en, pop, clr_drop;
  logic [7:0]      in_data;
  logic [RA_W-1:0] rd_addr;

  iob_eth_rx_ring_if #(.DATA_W(DATA_W), .SLOT_ADDR_W(SLOT_ADDR_W), .NSLOTS_W(NSLOTS_W)) bus0 ();
  iob_eth_rx_ring_if #(.DATA_W(DATA_W), .SLOT_ADDR_W(SLOT_ADDR_W), .NSLOTS_W(NSLOTS_W)) bus1 ();

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.in_data  = in_data;   assign bus1.in_data  = in_data;
  assign bus0.in_sof   = in_sof;    assign bus1.in_sof   = in_sof;
  assign bus0.in_eof   = in_eof;    assign bus1.in_eof   = in_eof;
  assign bus0.in_err   = in_err;    assign bus1.in_err   = in_err;
  assign bus0.rd_en    = rd_en;     assign bus1.rd_en    = rd_en;
  assign bus0.rd_addr  = rd_addr;   assign bus1.rd_addr  = rd_addr;
  assign bus0.pop      = pop;       assign bus1.pop      = pop;
  assign bus0.clr_drop = clr_drop;  assign bus1.clr_drop = clr_drop;

  iob_eth_rx_ring #(.DATA_W(DATA_W), .SLOT_ADDR_W(SLOT_ADDR_W), .NSLOTS_W(NSLOTS_W), .DROP_BAD(0))
    dut0 (.clk(clk), .rst_n(rst_n), .ring_if(bus0));
  iob_eth_rx_ring #(.DATA_W(DATA_W), .SLOT_ADDR_W(SLOT_ADDR_W), .NSLOTS_W(NSLOTS_W), .DROP_BAD(1))
    dut1 (.clk(clk), .rst_n(rst_n), .ring_if(bus1));

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] sb_bytes[$];
  int         sb_len[$];
  bit         sb_crc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0; in_data = '0;
    rd_en = 1'b0; rd_addr = '0; pop = 1'b0; clr_drop = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    sb_bytes.delete(); sb_len.delete(); sb_crc.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit sof, input bit eof, input bit err,
                           input bit p, input bit clr);
    in_valid = 1'b1; in_data = d; in_sof = sof; in_eof = eof; in_err = err;
    pop = p; clr_drop = clr;
    tick();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0; pop = 1'b0; clr_drop = 1'b0;
  endtask

  // Sends len bytes seed, seed+1, ...; sb_push queues the frame as an expected commit
  task automatic send_frame(input int len, input int seed, input bit err, input bit sb_push,
                            input bit pop_last);
    for (int i = 0; i < len; i++) begin
      if (sb_push) sb_bytes.push_back(8'(seed + i));
      send_byte(8'(seed + i), i == 0, i == len - 1, err && (i == len - 1),
                pop_last && (i == len - 1), 1'b0);
    end
    if (sb_push) begin
      sb_len.push_back(len);
      sb_crc.push_back(!err);
    end
  endtask

  task automatic read_word(input int a, output logic [31:0] w);
    rd_en = 1'b1; rd_addr = RA_W'(a);
    tick();
    rd_en = 1'b0;
    w = bus0.rd_data;
  endtask

  task automatic pop_head();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic discard_expected();
    int len;
    len = sb_len.pop_front();
    void'(sb_crc.pop_front());
    for (int i = 0; i < len; i++) void'(sb_bytes.pop_front());
  endtask

  // Compares dut0's head frame against the oldest expected frame, then pops it
  task automatic drain_frame(input string tag);
    int len, nw;
    bit crc;
    logic [31:0] got, exp, mask;
    check({tag, "_sb_nonempty"}, 64'(sb_len.size() != 0), 64'(1));
    if (sb_len.size() == 0) return;
    len = sb_len.pop_front();
    crc = sb_crc.pop_front();
    check({tag, "_len"}, 64'(bus0.head_len), 64'(len));
    check({tag, "_crc"}, 64'(bus0.head_crc_ok), 64'(crc));
    nw = (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      exp = '0; mask = '0;
      for (int l = 0; l < 4; l++) begin
        if (w * 4 + l < len) begin
          exp[l*8 +: 8]  = sb_bytes.pop_front();
          mask[l*8 +: 8] = 8'hFF;
        end
      end
      read_word(w, got);
      check({tag, "_data"}, 64'(got & mask), 64'(exp));
    end
    pop_head();
  endtask

  initial begin
    logic [31:0] w;

    // Reset values
    do_reset();
    check("rst_empty", 64'(bus0.empty), 64'(1));
    check("rst_full", 64'(bus0.full), 64'(0));
    check("rst_count", 64'(bus0.count), 64'(0));
    check("rst_head_len", 64'(bus0.head_len), 64'(0));
    check("rst_crc", 64'(bus0.head_crc_ok), 64'(0));
    check("rst_drop", 64'(bus0.drop_cnt), 64'(0));
    check("rst_rd_data", 64'(bus0.rd_data), 64'(0));

    // Single 64-byte frame 0x00..0x3F
    send_frame(64, 0, 1'b0, 1'b1, 1'b0);
    check("single_count", 64'(bus0.count), 64'(1));
    check("single_empty", 64'(bus0.empty), 64'(0));
    read_word(0, w);
    check("single_word0", 64'(w), 64'(32'h03020100));
    check("single_rd_hold", 64'(bus0.rd_data), 64'(32'h03020100));
    drain_frame("single");
    check("single_empty_after", 64'(bus0.empty), 64'(1));

    // Five back-to-back 60-byte frames into four slots
    do_reset();
    for (int f = 0; f < 5; f++) send_frame(60, f * 40, 1'b0, f < 4, 1'b0);
    check("full_full", 64'(bus0.full), 64'(1));
    check("full_count", 64'(bus0.count), 64'(4));
    check("full_drop", 64'(bus0.drop_cnt), 64'(1));
    for (int f = 0; f < 4; f++) drain_frame("full");
    check("full_empty_after", 64'(bus0.empty), 64'(1));
    pop_head();
    check("pop_while_empty", 64'(bus0.count), 64'(0));

    // Frame ending with in_err under both policies
    do_reset();
    send_frame(20, 8'h70, 1'b1, 1'b1, 1'b0);
    check("err_keep_count", 64'(bus0.count), 64'(1));
    check("err_drop_count", 64'(bus1.count), 64'(0));
    check("err_drop_empty", 64'(bus1.empty), 64'(1));
    check("err_drop_cnt", 64'(bus1.drop_cnt), 64'(1));
    check("err_keep_drop_cnt", 64'(bus0.drop_cnt), 64'(0));
    drain_frame("err_keep");

    // 2049-byte overflow followed by a 10-byte frame
    do_reset();
    send_frame(2049, 3, 1'b0, 1'b0, 1'b0);
    check("ovf_drop", 64'(bus0.drop_cnt), 64'(1));
    check("ovf_count0", 64'(bus0.count), 64'(0));
    send_frame(10, 8'hA0, 1'b0, 1'b1, 1'b0);
    check("ovf_count", 64'(bus0.count), 64'(1));
    drain_frame("ovf_next");

    // 1-byte frame, then a sof in the middle of a frame
    do_reset();
    send_frame(1, 8'h5A, 1'b0, 1'b1, 1'b0);
    check("one_count", 64'(bus0.count), 64'(1));
    drain_frame("one");
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), i == 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(12, 8'h21, 1'b0, 1'b1, 1'b0);
    check("restart_drop", 64'(bus0.drop_cnt), 64'(1));
    check("restart_count", 64'(bus0.count), 64'(1));
    drain_frame("restart");

    // Reset in the middle of a frame
    for (int i = 0; i < 7; i++) send_byte(8'(i), i == 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("midrst_count", 64'(bus0.count), 64'(0));
    check("midrst_drop", 64'(bus0.drop_cnt), 64'(0));
    send_frame(8, 8'h33, 1'b0, 1'b1, 1'b0);
    drain_frame("midrst");

    // Commit and pop in the same cycle with two frames queued
    do_reset();
    send_frame(20, 8'h10, 1'b0, 1'b1, 1'b0);
    send_frame(24, 8'h40, 1'b0, 1'b1, 1'b0);
    check("cp_count_before", 64'(bus0.count), 64'(2));
    send_frame(16, 8'h80, 1'b0, 1'b1, 1'b1);
    discard_expected();
    check("cp_count_after", 64'(bus0.count), 64'(2));
    check("cp_full", 64'(bus0.full), 64'(0));
    drain_frame("cp_a");
    drain_frame("cp_b");
    check("cp_empty", 64'(bus0.empty), 64'(1));

    // clr_drop racing a drop, then drop counter saturation
    do_reset();
    for (int f = 0; f < 4; f++) send_frame(2, f, 1'b0, 1'b0, 1'b0);
    check("sat_full", 64'(bus0.full), 64'(1));
    send_byte(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("clr_pre", 64'(bus0.drop_cnt), 64'(1));
    send_byte(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_wins", 64'(bus0.drop_cnt), 64'(0));
    for (int i = 0; i < 65535; i++) send_byte(8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_reach", 64'(bus0.drop_cnt), 64'(16'hFFFF));
    send_byte(8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_hold", 64'(bus0.drop_cnt), 64'(16'hFFFF));
    check("sat_count", 64'(bus0.count), 64'(4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
